desloca_iter: RTL and testbench
===============================

# desloca_iter

Parametrised, multi-cycle successor to the fixed shift-left-by-2 offset unit. It shifts a `WIDTH`-bit operand by a run-time amount, `STEP` bit positions per clock, under a start/done handshake. Modes are logical left, logical right, arithmetic right and (optionally) rotate-left. It sits beside the ALU in the multi-cycle datapath, serving SLL/SRL/SRA/SLLV/SRLV/SRAV and the branch-offset `<<2`.

## Interface
- `WIDTH`, 32: operand width in bits, ≥ 2.
- `STEP`, 1: bit positions shifted per cycle; power of two, 1 ≤ `STEP` ≤ `WIDTH`.
- `SW`, `$clog2(WIDTH)`: derived localparam; shift-amount width.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request; sampled only in IDLE or DONE.
- `modo` in 2: operation. 00 = SLL, 01 = SRL, 10 = SRA, 11 = ROTL (see Configuration).
- `shamt` in SW: shift amount, 0..WIDTH-1.
- `dado_in` in WIDTH: operand.
- `busy` out 1: high while in SHIFT.
- `done` out 1: one-cycle pulse when `dado_out` is valid.
- `dado_out` out WIDTH: result; holds until the next result is written.

## Operation
- The FSM has three states: IDLE, SHIFT, DONE.
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `dado_out` = 0, internal work register = 0, remaining count = 0.
- IDLE:
  - `start` = 1 captures `dado_in`, `shamt` and `modo` into internal registers and moves to SHIFT.
  - `start` = 0 stays in IDLE.
- SHIFT, with remaining count `r`:
  - `r` = 0 → move to DONE without shifting.
  - `r` > 0 → shift the work register by `s` = min(`STEP`, `r`) and set `r` ← `r` − `s`.
  - If the new `r` = 0, write `dado_out` ← result in the same edge and move to DONE; otherwise stay in SHIFT.
- Fill rules:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA replicates bit `WIDTH-1` of the captured operand.
  - ROTL wraps bits from the MSB into the LSB.
- The `shamt` = 0 path also writes `dado_out` ← captured operand when entering DONE.
- DONE:
  - `done` = 1 for exactly this cycle.
  - `start` = 1 is accepted exactly as in IDLE (back-to-back operation); otherwise move to IDLE.
- `start` during SHIFT is ignored and not queued. Inputs may change freely after the capture edge.
- `reset` = 1 mid-operation aborts the operation at the next edge and restores every reset value. No `done` is produced for the aborted request.
- Results are exact for any `shamt` ≤ `WIDTH`-1; there is no overflow or wrap of the amount.

## Timing
- `start` is sampled at edge k. `busy` = 1 from edge k until the edge that enters DONE.
- With N = ceil(`shamt`/`STEP`), `done` and the new `dado_out` become visible after edge k + max(N, 1).
  - `STEP` = 1, `shamt` = 2: `done` after k+2.
  - `shamt` = 0: `done` after k+1.
  - `STEP` = `WIDTH`: every operation completes after k+1.
- Back-to-back throughput is one result per max(N, 1) + 1 cycles.
- `done` and `busy` are never high in the same cycle.
- Every output is registered; there is no combinational input-to-output path.

## Configuration
- Macro: `DESLOCA_ROT_EN`.
- Defined: `modo` = 11 performs rotate-left by `shamt`, with the same latency as the other modes.
- Undefined: `modo` = 11 behaves exactly as SLL, and no rotate logic is synthesised.

## Test plan
- Reset values: hold `reset` 3 cycles with `start` = 1 → `busy` = 0, `done` = 0, `dado_out` = 0. After release, `start` with SLL, `shamt` = 2, `dado_in` = 0x0000_0001 → `done` pulse after 2 edges (`STEP` = 1), `dado_out` = 0x0000_0004.
- Branch-offset equivalence: SLL by 2 on 0x4000_0000, 0xFFFF_FFFF, 0x1234_5678, 0x8765_4321 → 0x0000_0000, 0xFFFF_FFFC, 0x48D1_59E0, 0x1D95_0C84.
- SRA vs SRL, `shamt` = 4, `dado_in` = 0x8765_4321 → SRA = 0xF876_5432, SRL = 0x0876_5432.
- Latency with `STEP` = 4: SRL, `shamt` = 31 → `done` after edge k+8. Under `DESLOCA_ROT_EN`, ROTL by 8 on 0x1234_5678 → 0x3456_7812; without the macro, the same stimulus → 0x3456_7800.
- Handshake and boundaries:
  - `shamt` = 0 → `done` after k+1 and `dado_out` = `dado_in`.
  - `start` pulsed mid-SHIFT → ignored, exactly one `done`.
  - `start` held during DONE → the next operation starts with no IDLE cycle.
- Abort: `reset` asserted two cycles into SLL, `shamt` = 20 → no `done`, and all outputs read 0 on the following cycle.

Source files
------------

// File: rtl/desloca_iter.sv
// desloca_iter: multi-cycle SLL/SRL/SRA shifter, STEP bits per clock, start/done handshake.
// Define DESLOCA_ROT_EN to make modo=11 rotate-left; otherwise modo=11 acts as SLL.
module desloca_iter #(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       modo,
  input  logic [SW-1:0]    shamt,
  input  logic [WIDTH-1:0] dado_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dado_out
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SW:0] STEP_W = (SW+1)'(STEP);
`ifdef DESLOCA_ROT_EN
  localparam logic [SW:0] WIDTH_W = (SW+1)'(WIDTH);
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d, dado_out_q, dado_out_d, shifted, rot;
  logic [SW-1:0] rem_q, rem_d, rem_next;
  logic [1:0] modo_q, modo_d;
  logic [SW:0] s;
  always_comb begin
    s = ({1'b0, rem_q} >= STEP_W) ? STEP_W : {1'b0, rem_q};
    rem_next = rem_q - s[SW-1:0];
`ifdef DESLOCA_ROT_EN
    rot = (work_q << s) | (work_q >> (WIDTH_W - s));
`else
    rot = work_q << s;
`endif
    // SRA stays exact across steps because the work register keeps its sign bit
    shifted = modo_q == 2'b01 ? work_q >> s :
              modo_q == 2'b10 ? WIDTH'($signed(work_q) >>> s) :
              modo_q == 2'b11 ? rot : work_q << s;
  end
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    rem_d = rem_q;
    modo_d = modo_q;
    dado_out_d = dado_out_q;
    if (state_q != SHIFT && start) begin
      state_d = SHIFT;
      work_d = dado_in;
      rem_d = shamt;
      modo_d = modo;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (state_q == SHIFT) begin
      work_d = shifted;
      rem_d = rem_next;
      if (rem_next == '0) begin
        state_d = DONE;
        dado_out_d = shifted;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q <= '0;
      rem_q <= '0;
      modo_q <= '0;
      dado_out_q <= '0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      rem_q <= rem_d;
      modo_q <= modo_d;
      dado_out_q <= dado_out_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  assign dado_out = dado_out_q;
endmodule

// File: tb/tb_desloca_iter.sv
// tb_desloca_iter: directed scoreboard bench for desloca_iter, STEP=1 and STEP=4 instances.
module tb_desloca_iter;
  logic clk = 0, reset = 1, start = 0, sel = 0;
  logic [1:0] modo = 0;
  logic [4:0] shamt = 0;
  logic [31:0] dado_in = 0;
  logic busy1, done1, busy4, done4, o_busy, o_done;
  logic [31:0] out1, out4, o_out;
  logic [31:0] exp_q[$];
  int nerr = 0, nchk = 0;

  always #5 clk = ~clk;

  desloca_iter dut1 (.clk(clk), .reset(reset), .start(start & ~sel), .modo(modo), .shamt(shamt),
                     .dado_in(dado_in), .busy(busy1), .done(done1), .dado_out(out1));
  desloca_iter #(.STEP(4)) dut4 (.clk(clk), .reset(reset), .start(start & sel), .modo(modo), .shamt(shamt),
                     .dado_in(dado_in), .busy(busy4), .done(done4), .dado_out(out4));

  assign o_busy = sel ? busy4 : busy1;
  assign o_done = sel ? done4 : done1;
  assign o_out = sel ? out4 : out1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] m, input int sh, input logic [31:0] d);
    case (m)
      2'b01: return d >> sh;
      2'b10: return 32'($signed(d) >>> sh);
`ifdef DESLOCA_ROT_EN
      2'b11: return 32'(({d, d} << sh) >> 32);
`endif
      default: return d << sh;
    endcase
  endfunction

  task automatic run_op(input logic s4, input logic [1:0] m, input int sh, input logic [31:0] d,
                        input logic [31:0] exp, input string tag);
    int lat, n;
    logic [31:0] e;
    lat = sh == 0 ? 1 : (s4 ? (sh + 3) / 4 : sh);
    exp_q.push_back(exp);
    @(negedge clk);
    sel = s4; modo = m; shamt = 5'(sh); dado_in = d; start = 1;
    @(posedge clk);
    #1 start = 0; dado_in = ~d; modo = ~m; shamt = ~shamt;
    chk({tag, "_busy"}, {31'b0, o_busy}, 32'd1);
    n = 0;
    while (!o_done && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_nobusy"}, {31'b0, o_busy}, 32'd0);
    e = exp_q.pop_front();
    chk({tag, "_out"}, o_out, e);
  endtask

  initial begin
    logic [31:0] br_in [4] = '{32'h4000_0000, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8765_4321};
    logic [31:0] br_ex [4] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h48D1_59E0, 32'h1D95_0C84};
    logic [31:0] e, got;
    int ndone;
    reset = 1; start = 1; modo = 0; shamt = 2; dado_in = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy1}, 0);
    chk("rst_done", {31'b0, done1}, 0);
    chk("rst_out", out1, 0);
    chk("rst_out4", out4, 0);
    @(negedge clk) reset = 0; start = 0;
    run_op(0, 2'b00, 2, 32'h1, 32'h4, "sll2");
    for (int i = 0; i < 4; i++) run_op(0, 2'b00, 2, br_in[i], br_ex[i], $sformatf("br%0d", i));
    run_op(0, 2'b10, 4, 32'h8765_4321, 32'hF876_5432, "sra4");
    run_op(0, 2'b01, 4, 32'h8765_4321, 32'h0876_5432, "srl4");
    run_op(0, 2'b10, 3, 32'h7000_0000, model(2'b10, 3, 32'h7000_0000), "sra_pos");
    run_op(0, 2'b00, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, "sh0");
    run_op(1, 2'b01, 31, 32'h8765_4321, 32'h0000_0001, "s4_srl31");
    run_op(1, 2'b10, 5, 32'h8000_0000, model(2'b10, 5, 32'h8000_0000), "s4_sra5");
    run_op(1, 2'b00, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, "s4_sh0");
`ifdef DESLOCA_ROT_EN
    run_op(1, 2'b11, 8, 32'h1234_5678, 32'h3456_7812, "s4_rot8");
    run_op(0, 2'b11, 3, 32'hE000_0001, model(2'b11, 3, 32'hE000_0001), "rot3");
`else
    run_op(1, 2'b11, 8, 32'h1234_5678, 32'h3456_7800, "s4_rot8");
`endif
    // start pulsed while shifting must be dropped
    exp_q.push_back(32'h60);
    @(negedge clk) sel = 0; modo = 0; shamt = 5; dado_in = 3; start = 1;
    @(posedge clk) #1 start = 0;
    @(negedge clk);
    @(negedge clk) start = 1; dado_in = 32'hFFFF; shamt = 1; modo = 1;
    @(negedge clk) start = 0;
    ndone = 0; got = 0;
    repeat (15) begin
      @(posedge clk);
      #1 if (done1) begin ndone++; got = out1; end
    end
    chk("mid_ndone", ndone, 1);
    e = exp_q.pop_front();
    chk("mid_out", got, e);
    // back-to-back with start held through DONE
    exp_q.push_back(32'h2);
    exp_q.push_back(32'h8);
    @(negedge clk) modo = 0; shamt = 1; dado_in = 1; start = 1;
    @(posedge clk) #1;
    @(posedge clk) #1;
    chk("b2b_done1", {31'b0, done1}, 1);
    e = exp_q.pop_front();
    chk("b2b_out1", out1, e);
    modo = 1; shamt = 1; dado_in = 32'h10;
    @(posedge clk) #1;
    chk("b2b_gap_done", {31'b0, done1}, 0);
    chk("b2b_noidle", {31'b0, busy1}, 1);
    start = 0;
    @(posedge clk) #1;
    chk("b2b_done2", {31'b0, done1}, 1);
    e = exp_q.pop_front();
    chk("b2b_out2", out1, e);
    // abort mid-operation
    @(negedge clk) modo = 0; shamt = 20; dado_in = 1; start = 1;
    @(posedge clk) #1 start = 0;
    @(posedge clk);
    @(negedge clk) reset = 1;
    @(posedge clk) #1;
    chk("abort_busy", {31'b0, busy1}, 0);
    chk("abort_done", {31'b0, done1}, 0);
    chk("abort_out", out1, 0);
    @(negedge clk) reset = 0;
    ndone = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (done1) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    chk("abort_out_hold", out1, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
